// File: rtl/decoder_pkg.sv
// Shared helpers for the writeback write-enable decoder: enable-vector sizing
// and the default hardwired-zero register index.
package decoder_pkg;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int ADDR_W_DEF   = 5;
  localparam int DEPTH_DEF    = depth(ADDR_W_DEF);
  localparam int ZERO_REG_DEF = 31;

  // One-hot write-enable vector for a single port at the default address width
  typedef logic [DEPTH_DEF-1:0] onehot_t;

endpackage

// File: rtl/dec_onehot.sv
// Combinational enable + address to one-hot decoder (generalised 5-to-32).
module dec_onehot
  import decoder_pkg::*;
#(
  parameter  int ADDR_W = 5,
  localparam int DEPTH  = depth(ADDR_W)
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  y
);

  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/wb_wren_decoder.sv
// Registered multi-port register-file write-enable decoder with zero-register
// masking, same-cycle conflict resolution and a saturating conflict counter.
module wb_wren_decoder
  import decoder_pkg::*;
#(
  parameter  int ADDR_W   = 5,
  parameter  int NPORTS   = 2,
  parameter  int ZERO_EN  = 1,
  parameter  int ZERO_REG = ZERO_REG_DEF,
  parameter  int CNT_W    = 8,
  localparam int DEPTH    = depth(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NPORTS-1:0]        en,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  output logic [NPORTS*DEPTH-1:0]  y,
  output logic [DEPTH-1:0]         y_any,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [NPORTS-1:0][ADDR_W-1:0] addr_v;
  logic [NPORTS-1:0]             req;
  logic [NPORTS-1:0][DEPTH-1:0]  dec;
  logic [NPORTS-1:0][DEPTH-1:0]  res;
  logic [DEPTH-1:0]              higher;
  logic [DEPTH-1:0]              any_n;
  logic                          drop;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign addr_v[p] = addr[p*ADDR_W +: ADDR_W];
    assign req[p]    = en[p] && !((ZERO_EN != 0) && (addr_v[p] == ZERO_ADDR));

    dec_onehot #(.ADDR_W(ADDR_W)) u_dec (
      .en   (req[p]),
      .addr (addr_v[p]),
      .y    (dec[p])
    );
  end

  // Walk from the youngest port down: a port whose line is already claimed by
  // a higher-index port is dropped whole, so each line has exactly one owner.
  always_comb begin
    higher = '0;
    any_n  = '0;
    res    = '0;
    drop   = 1'b0;
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if ((dec[p] & higher) != '0) drop = 1'b1;
      else                         res[p] = dec[p];
      higher = higher | dec[p];
      any_n  = any_n | res[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y            <= '0;
      y_any        <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (flush) begin
      y        <= '0;
      y_any    <= '0;
      conflict <= 1'b0;
    end else if (!stall) begin
      y        <= res;
      y_any    <= any_n;
      conflict <= drop;
      if (drop && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_wren_decoder.sv
// Self-checking bench: three decoder configurations driven by directed and
// random stimulus, compared against a per-port winner model.
module tb_wb_wren_decoder;

  logic       clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0] en0 = '0;
  logic [9:0] addr0 = '0;
  logic [2:0] en2 = '0;
  logic [8:0] addr2 = '0;

  logic [63:0] y0, y1;
  logic [31:0] any0, any1;
  logic        c0, c1, c2;
  logic [1:0]  cnt0;
  logic [7:0]  cnt1;
  logic [23:0] y2;
  logic [7:0]  any2;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  wb_wren_decoder #(.ADDR_W(5), .NPORTS(2), .ZERO_EN(1), .ZERO_REG(31), .CNT_W(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .en(en0), .addr(addr0),
    .y(y0), .y_any(any0), .conflict(c0), .conflict_cnt(cnt0));

  wb_wren_decoder #(.ADDR_W(5), .NPORTS(2), .ZERO_EN(0), .ZERO_REG(31), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .en(en0), .addr(addr0),
    .y(y1), .y_any(any1), .conflict(c1), .conflict_cnt(cnt1));

  wb_wren_decoder #(.ADDR_W(3), .NPORTS(3), .ZERO_EN(1), .ZERO_REG(0), .CNT_W(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .en(en2), .addr(addr2),
    .y(y2), .y_any(any2), .conflict(c2), .conflict_cnt(cnt2));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per configuration, the spec's winner rule in plain ints
  int AW[3] = '{5, 5, 3};
  int NP[3] = '{2, 2, 3};
  int ZE[3] = '{1, 0, 1};
  int ZR[3] = '{31, 31, 0};
  int CW[3] = '{2, 8, 4};

  logic [127:0] ey[3];
  logic [31:0]  eany[3];
  logic         ec[3];
  int           ecnt[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ey[k] = '0; eany[k] = '0; ec[k] = 1'b0; ecnt[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 3; k++) begin
      int  e[4];
      int  a[4];
      bit  req[4];
      bit  drop;
      int  d;
      d = 1 << AW[k];
      if (flush) begin
        ey[k] = '0; eany[k] = '0; ec[k] = 1'b0;
      end else if (!stall) begin
        for (int p = 0; p < NP[k]; p++) begin
          if (k < 2) begin e[p] = int'(en0[p]); a[p] = int'(addr0[p*5 +: 5]); end
          else       begin e[p] = int'(en2[p]); a[p] = int'(addr2[p*3 +: 3]); end
          req[p] = (e[p] != 0) && !(ZE[k] != 0 && a[p] == ZR[k]);
        end
        ey[k] = '0; eany[k] = '0; drop = 1'b0;
        for (int p = 0; p < NP[k]; p++) begin
          if (req[p]) begin
            bit won;
            won = 1'b1;
            for (int q = p + 1; q < NP[k]; q++)
              if (req[q] && a[q] == a[p]) won = 1'b0;
            if (won) begin
              ey[k][p*d + a[p]] = 1'b1;
              eany[k][a[p]]     = 1'b1;
            end else drop = 1'b1;
          end
        end
        ec[k] = drop;
        if (drop && ecnt[k] < (1 << CW[k]) - 1) ecnt[k]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit ok;
    logic [7:0] acc;
    chk({tag, "_y0"},   y0,   ey[0]);
    chk({tag, "_any0"}, any0, 128'(eany[0]));
    chk({tag, "_c0"},   c0,   128'(ec[0]));
    chk({tag, "_cnt0"}, cnt0, 128'(ecnt[0]));
    chk({tag, "_y1"},   y1,   ey[1]);
    chk({tag, "_any1"}, any1, 128'(eany[1]));
    chk({tag, "_c1"},   c1,   128'(ec[1]));
    chk({tag, "_cnt1"}, cnt1, 128'(ecnt[1]));
    chk({tag, "_y2"},   y2,   ey[2]);
    chk({tag, "_any2"}, any2, 128'(eany[2]));
    chk({tag, "_c2"},   c2,   128'(ec[2]));
    chk({tag, "_cnt2"}, cnt2, 128'(ecnt[2]));
    ok = 1'b1; acc = '0;
    for (int p = 0; p < 3; p++) begin
      if ($countones(y2[p*8 +: 8]) > 1) ok = 1'b0;
      if ((acc & y2[p*8 +: 8]) != '0)   ok = 1'b0;
      acc = acc | y2[p*8 +: 8];
    end
    chk({tag, "_inv2"}, 128'(ok), 128'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1 check_all(tag);
  endtask

  function automatic logic [4:0] pick5();
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(28, 31));
  endfunction

  int sat_exp[4] = '{1, 2, 3, 3};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst");
    @(negedge clk) rst_n = 1'b1;

    en0 = 2'b11; addr0 = {5'd3, 5'd7};
    step("load");
    chk("load_any", any0, 128'h88);
    chk("load_y7",  y0[7],  1);
    chk("load_y35", y0[35], 1);

    // asynchronous reset mid-cycle while stalled clears without an edge
    #3 stall = 1'b1; rst_n = 1'b0;
    #1 model_reset(); check_all("arst");
    @(posedge clk); #1 check_all("arst_hold");
    @(negedge clk) rst_n = 1'b1; stall = 1'b0;
    step("post_rst");
    chk("post_any", any0, 128'h88);
    chk("post_c",   c0,   0);

    en0 = 2'b01; addr0 = {5'd0, 5'd31};
    step("zero");
    chk("zero_y0",    y0,     0);
    chk("zero_any0",  any0,   0);
    chk("zero_y1_31", y1[31], 1);

    en0 = 2'b11; addr0 = {5'd5, 5'd5};
    step("conf");
    chk("conf_lo",  y0[31:0], 0);
    chk("conf_hi",  y0[37],   1);
    chk("conf_any", any0,     128'h20);
    chk("conf_c",   c0,       1);
    chk("conf_cnt", cnt1,     1);

    en0 = 2'b01; addr0 = {5'd0, 5'd2};
    step("ld2");
    stall = 1'b1; addr0 = {5'd0, 5'd9};
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_y2", y0, 128'h4);
    end
    flush = 1'b1; en0 = 2'b11; addr0 = {5'd4, 5'd4};
    step("flush");
    chk("flush_any", any0, 0);
    chk("flush_c",   c1,   0);
    chk("flush_cnt", cnt1, 1);
    flush = 1'b0; stall = 1'b0;

    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk) rst_n = 1'b1;
    en0 = 2'b11; addr0 = {5'd6, 5'd6};
    for (int i = 0; i < 4; i++) begin
      step("sat");
      chk("sat_cnt", cnt0, 128'(sat_exp[i]));
      chk("sat_c",   c0,   1);
    end

    for (int e = 0; e < 8; e++) begin
      for (int a = 0; a < 512; a++) begin
        en2 = 3'(e); addr2 = 9'(a);
        en0 = 2'($urandom); addr0 = {pick5(), pick5()};
        step("sweep");
      end
    end

    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      en0 = 2'($urandom); addr0 = {pick5(), pick5()};
      en2 = 3'($urandom); addr2 = 9'($urandom_range(0, 511));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
